// File: rtl/pdu_imem_arbiter.sv
// -----------------------------------------------------------------------------
// pdu_imem_arbiter
//
// Shares the single-port instruction memory (BRAM with a 1-cycle registered
// read) between the CPU fetch port (read-only) and the PDU debug/loader port
// (read/write). One access is granted per cycle. Read data comes back from
// the memory one cycle after the grant and is steered to the requester that
// owned that grant.
//
// Handshake (both requesters): a requester holds req/addr/we/wdata stable
// until it sees gnt high in the same cycle; the transfer happens on the
// rising edge where req && gnt. A requester may drop req without a grant.
// At most one gnt is high per cycle. rvalid is a one-cycle pulse with no
// back-pressure: the requester must take rdata while rvalid is high.
//
// Arbitration: the PDU wins ties, but after PDU_BURST consecutive PDU grants
// with the CPU waiting, the CPU is forced one grant so a streaming loader
// cannot starve instruction fetch.
//
// Ports:
//   sys_clk, sys_rst       clock, synchronous active-high reset
//   cpu_req/addr           CPU fetch request and word address
//   cpu_gnt                CPU request accepted this cycle (combinational)
//   cpu_rvalid/rdata       CPU read return, one cycle after grant
//   cpu_flush              discard CPU read data in flight / being issued
//   pdu_req/we/addr/wdata  PDU access request
//   pdu_gnt                PDU request accepted this cycle (combinational)
//   pdu_rvalid/rdata       PDU read return, one cycle after grant
//   mem_addr/we/wdata      IMEM drive
//   mem_rdata              IMEM read data (valid cycle after address)
// -----------------------------------------------------------------------------
module pdu_imem_arbiter #(
  parameter int DEPTH     = 12,
  parameter int PDU_BURST = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cpu_req,
  input  logic [DEPTH-1:0] cpu_addr,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  input  logic             cpu_flush,
  input  logic             pdu_req,
  input  logic             pdu_we,
  input  logic [DEPTH-1:0] pdu_addr,
  input  logic [31:0]      pdu_wdata,
  output logic             pdu_gnt,
  output logic             pdu_rvalid,
  output logic [31:0]      pdu_rdata,
  output logic [DEPTH-1:0] mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(PDU_BURST);

  // Consecutive PDU grants taken while the CPU was waiting.
  logic [3:0] bcnt_q, bcnt_d;
  // Owner tag for the read that the memory is returning this cycle.
  logic       rd_cpu_q, rd_cpu_d;
  logic       rd_pdu_q, rd_pdu_d;
  logic       burst_full;

  assign burst_full = (bcnt_q == BURST_MAX);

  // Grants are purely combinational from the requests and the burst count,
  // and are held off entirely while reset is asserted.
  always_comb begin
    cpu_gnt = 1'b0;
    pdu_gnt = 1'b0;
    if (!sys_rst) begin
      cpu_gnt = cpu_req && (!pdu_req || burst_full);
      pdu_gnt = pdu_req && (!cpu_req || !burst_full);
    end
  end

  // The counter only advances while the CPU is actually being made to wait;
  // any CPU grant or an idle CPU restarts the burst window. Because the PDU
  // is only granted against a waiting CPU while bcnt < PDU_BURST, the count
  // saturates at PDU_BURST.
  always_comb begin
    bcnt_d = 4'd0;
    if (pdu_gnt && cpu_req) begin
      bcnt_d = bcnt_q + 4'd1;
    end
  end

  always_comb begin
    mem_addr = '0;
    if (cpu_gnt) begin
      mem_addr = cpu_addr;
    end else if (pdu_gnt) begin
      mem_addr = pdu_addr;
    end
  end

  assign mem_we    = pdu_gnt && pdu_we;
  assign mem_wdata = pdu_wdata;

  // A flush in the grant cycle kills the tag; a flush in the return cycle
  // masks the valid below.
  assign rd_cpu_d = cpu_gnt && !cpu_flush;
  assign rd_pdu_d = pdu_gnt && !pdu_we;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bcnt_q   <= 4'd0;
      rd_cpu_q <= 1'b0;
      rd_pdu_q <= 1'b0;
    end else begin
      bcnt_q   <= bcnt_d;
      rd_cpu_q <= rd_cpu_d;
      rd_pdu_q <= rd_pdu_d;
    end
  end

  // Valids are also masked by reset so a read granted just before reset
  // never shows up as a return while reset is held.
  assign cpu_rvalid = rd_cpu_q && !cpu_flush && !sys_rst;
  assign pdu_rvalid = rd_pdu_q && !sys_rst;
  assign cpu_rdata  = mem_rdata;
  assign pdu_rdata  = mem_rdata;

endmodule

// File: doc/pdu_imem_arbiter.md
Name: pdu_imem_arbiter

Overview:
- Shares the single-port instruction memory (block RAM, 1-cycle registered read) between two requesters:
  - the CPU fetch port, read-only;
  - the PDU debug/loader port, read and write.
- Sits between both requesters and the IMEM array.
- Grants one access per cycle and routes the read data back to whichever requester owns it one cycle later.
- The CPU cannot be starved by a streaming PDU loader.

Parameters:
- DEPTH, 12, IMEM address width in words (array holds 1<<DEPTH words).
- PDU_BURST, 4, maximum consecutive PDU grants while the CPU is requesting before the CPU is forced a grant (range 1..15).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous active-high reset.
- cpu_req  in  1  CPU fetch request.
- cpu_addr  in  DEPTH  CPU fetch word address.
- cpu_gnt  out  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU read data valid (registered).
- cpu_rdata  out  32  CPU read data.
- cpu_flush  in  1  discard an in-flight CPU read.
- pdu_req  in  1  PDU access request.
- pdu_we  in  1  1 = write, 0 = read.
- pdu_addr  in  DEPTH  PDU word address.
- pdu_wdata  in  32  PDU write data.
- pdu_gnt  out  1  PDU request accepted this cycle (combinational).
- pdu_rvalid  out  1  PDU read data valid (registered).
- pdu_rdata  out  32  PDU read data.
- mem_addr  out  DEPTH  IMEM address.
- mem_we  out  1  IMEM write enable.
- mem_wdata  out  32  IMEM write data.
- mem_rdata  in  32  IMEM read data, valid the cycle after the address is presented.

Behaviour:
- Handshake
  - A requester holds req, addr, we and wdata stable until it sees gnt high in the same cycle.
  - A transfer occurs on the edge where req && gnt.
  - At most one of cpu_gnt / pdu_gnt is high in any cycle.
  - A requester may drop req without a grant.
- Arbitration (combinational from req inputs and burst counter bcnt)
  - Only cpu_req: CPU granted.
  - Only pdu_req: PDU granted.
  - Both requesting and bcnt < PDU_BURST: PDU granted.
  - Both requesting and bcnt == PDU_BURST: CPU granted.
- Burst counter bcnt (4 bits, reset 0)
  - PDU granted while cpu_req is high: bcnt increments.
  - CPU granted, or cpu_req is low: bcnt clears to 0.
  - bcnt never exceeds PDU_BURST.
- Memory drive
  - mem_addr = address of the granted requester; 0 when nothing is granted.
  - mem_we = pdu_gnt && pdu_we.
  - mem_wdata = pdu_wdata.
- Return path
  - Registered owner tag, two flops, reset 0:
    - rd_cpu <= cpu_gnt && !cpu_flush
    - rd_pdu <= pdu_gnt && !pdu_we
  - cpu_rvalid = rd_cpu && !cpu_flush. A flush in the return cycle also suppresses the data.
  - pdu_rvalid = rd_pdu.
  - cpu_rdata = pdu_rdata = mem_rdata. Each is meaningful only while its rvalid is high.
- Latency and throughput
  - Read data returns exactly 1 cycle after the grant.
  - Writes produce no rvalid; the grant cycle is the completion.
  - Back-to-back grants every cycle, no bubbles.
- Read-after-write
  - A PDU write at cycle N followed by any read of the same address at N+1 returns the new data, because the BRAM write completes at edge N.
- Reset
  - All outputs deassert on the edge where sys_rst is sampled high: gnt, rvalid, mem_we = 0; bcnt = 0.
  - Any in-flight read is dropped; no rvalid appears after reset.
  - Grants are forced low while sys_rst is high.
- cpu_flush
  - cpu_flush does not block a new CPU grant in the same cycle, but that grant's data is discarded.

Test Plan:
- Solo CPU fetch of addresses 0,1,2 on consecutive cycles with mem holding 0x00000013, 0x00100093, 0x00200113:
  - cpu_gnt high 3 cycles;
  - cpu_rvalid high cycles 1..3 with those words in order;
  - pdu_rvalid stays 0.
- PDU writes 0xDEADBEEF to addr 0x7FF, then CPU reads 0x7FF next cycle:
  - mem_we pulses once;
  - cpu_rdata = 0xDEADBEEF one cycle after cpu_gnt.
- Both requesting continuously, PDU_BURST=4:
  - grant pattern is P,P,P,P,C,P,P,P,P,C;
  - bcnt never exceeds 4.
- PDU read of addr 5 and CPU read of addr 6 back-to-back (PDU granted first):
  - pdu_rvalid with mem[5] in cycle N+1;
  - cpu_rvalid with mem[6] in cycle N+2;
  - never both valid together.
- CPU granted at N, cpu_flush high at N+1:
  - cpu_rvalid stays 0;
  - a CPU grant at N+1 also produces no rvalid at N+2.
- sys_rst asserted the cycle after a PDU read grant:
  - pdu_rvalid stays 0;
  - all grants low while reset is held;
  - bcnt = 0, and the arbitration pattern restarts at P after release.
